// File: rtl/gray_code_counter_if.sv
// Output bundle of the Gray-code counter: the registered count seen by downstream logic.
interface gray_code_counter_if #(
  parameter int N = 4
);
  logic [N-1:0] gray_code;

  modport master (output gray_code);
  modport slave  (input  gray_code);
endinterface

// File: rtl/gray_code_counter.sv
// Free-running N-bit Gray-code counter; one output bit changes per clock,
// so the count can be sampled safely from another clock domain.
module gray_code_counter #(
  parameter int N = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  gray_code_counter_if.master   gc
);

  logic [N-1:0] bin;
  logic [N-1:0] bin_nxt;
  logic [N-1:0] gray;

  function automatic logic [N-1:0] bin2gray(input logic [N-1:0] b);
    return b ^ (b >> 1);
  endfunction

  always_comb begin
    bin_nxt = bin + N'(1);
  end

  // The Gray value is registered from the next binary count, so the output
  // is a pure flop with no combinational path from bin within a cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      bin  <= '0;
      gray <= '0;
    end else begin
      bin  <= bin_nxt;
      gray <= bin2gray(bin_nxt);
    end
  end

  assign gc.gray_code = gray;

endmodule

// File: tb/tb_gray_code_counter.sv
// Directed bench for gray_code_counter at N = 1, 3, 4 and 8 sharing one clock and reset.
module tb_gray_code_counter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  gray_code_counter_if #(.N(1)) if1 ();
  gray_code_counter_if #(.N(3)) if3 ();
  gray_code_counter_if #(.N(4)) if4 ();
  gray_code_counter_if #(.N(8)) if8 ();

  gray_code_counter #(.N(1)) dut1 (.clk(clk), .reset(reset), .gc(if1));
  gray_code_counter #(.N(3)) dut3 (.clk(clk), .reset(reset), .gc(if3));
  gray_code_counter #(.N(4)) dut4 (.clk(clk), .reset(reset), .gc(if4));
  gray_code_counter #(.N(8)) dut8 (.clk(clk), .reset(reset), .gc(if8));

  int n_checks = 0;
  int n_pass   = 0;

  // Hand-written reflected-binary sequences
  int g4_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};
  int g3_tab [8]  = '{0, 1, 3, 2, 6, 7, 5, 4};

  logic [7:0] p1, p3, p4, p8;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input int k);
    int k8;
    k8 = k % 256;
    check({tag, "_n1"}, 8'(if1.gray_code), 8'(k % 2));
    check({tag, "_n3"}, 8'(if3.gray_code), 8'(g3_tab[k % 8]));
    check({tag, "_n4"}, 8'(if4.gray_code), 8'(g4_tab[k % 16]));
    check({tag, "_n8"}, if8.gray_code, 8'(k8 ^ (k8 >> 1)));
  endtask

  task automatic check_steps(input string tag);
    check({tag, "_1bit_n1"}, 8'($countones(p1 ^ 8'(if1.gray_code))), 8'd1);
    check({tag, "_1bit_n3"}, 8'($countones(p3 ^ 8'(if3.gray_code))), 8'd1);
    check({tag, "_1bit_n4"}, 8'($countones(p4 ^ 8'(if4.gray_code))), 8'd1);
    check({tag, "_1bit_n8"}, 8'($countones(p8 ^ if8.gray_code)), 8'd1);
  endtask

  task automatic save_prev();
    p1 = 8'(if1.gray_code);
    p3 = 8'(if3.gray_code);
    p4 = 8'(if4.gray_code);
    p8 = if8.gray_code;
  endtask

  initial begin
    reset = 1'b1;
    tick();
    check_all("reset1", 0);
    tick();
    check_all("reset2", 0);
    reset = 1'b0;
    save_prev();

    // Full N=4 sequence, wrap to 0000 then 0001, ending at 0110 (k=20)
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_all($sformatf("seq%0d", k), k);
      check_steps($sformatf("seq%0d", k));
      save_prev();
    end
    check("at_0110_n4", 8'(if4.gray_code), 8'b0000_0110);

    reset = 1'b1;
    tick();
    check_all("mid_reset", 0);
    reset = 1'b0;
    tick();
    check("after_rst1_n4", 8'(if4.gray_code), 8'b0000_0001);
    check_all("after_rst1", 1);
    save_prev();
    tick();
    check("after_rst2_n4", 8'(if4.gray_code), 8'b0000_0011);
    check_all("after_rst2", 2);
    check_steps("after_rst2");
    save_prev();

    // Run N=8 through its full 256-cycle period and past the wrap
    for (int k = 3; k <= 260; k++) begin
      tick();
      check_all($sformatf("long%0d", k), k);
      check_steps($sformatf("long%0d", k));
      if (k == 255) check("n8_last_code", if8.gray_code, 8'h80);
      if (k == 256) check("n8_wrap", if8.gray_code, 8'h00);
      if (k == 257) check("n8_after_wrap", if8.gray_code, 8'h01);
      save_prev();
    end

    reset = 1'b1;
    tick();
    tick();
    check_all("hold_reset", 0);
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
